// File: rtl/weight_loader_if.sv
// weight_loader_if: groups the configuration stream handshake and the
// weight-memory write port of one layer.
//   master : the host / configuration source (drives cfg_valid, cfg_data)
//   slave  : the weight loader (accepts the stream, drives the write port)
interface weight_loader_if #(
   parameter int dataWidth    = 16,
   parameter int addressWidth = 10,
   parameter int numNeuron    = 30
) ();

   logic                    cfg_valid;
   logic [dataWidth-1:0]    cfg_data;
   logic                    cfg_ready;
   logic                    wen;
   logic [addressWidth-1:0] wadd;
   logic [dataWidth-1:0]    win;
   logic [numNeuron-1:0]    wsel;
   logic                    done;
   logic                    err;
   logic [dataWidth-1:0]    checksum;

   modport master (
      output cfg_valid, cfg_data,
      input  cfg_ready, wen, wadd, win, wsel, done, err, checksum
   );

   modport slave (
      input  cfg_valid, cfg_data,
      output cfg_ready, wen, wadd, win, wsel, done, err, checksum
   );

endinterface

// File: rtl/weight_loader.sv
// weight_loader: write-side front end for the per-neuron weight memories of
// layer layerNo. A header word selects a neuron (cfg_data[7:0]) and a layer
// (cfg_data[15:8]); the next numWeight words are either written to that
// neuron's memory (addresses 0..numWeight-1) or discarded when the header
// targets another layer or an out-of-range neuron.
//
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to get a running modulo
// 2^dataWidth sum of the weights written for the current neuron on
// 'checksum'; without it 'checksum' is tied to zero.
module weight_loader #(
   parameter int numWeight    = 784,
   parameter int numNeuron    = 30,
   parameter int layerNo      = 1,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16
) (
   input  logic            clk,
   input  logic            rst,
   weight_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SKIP = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [addressWidth-1:0] last_idx = addressWidth'(numWeight - 1);
   localparam logic [numNeuron-1:0]    sel_one  = numNeuron'(1);

   state_t                  state_q;
   state_t                  state_d;

   logic                    ready_q;
   logic [addressWidth-1:0] cnt_q;
   logic [numNeuron-1:0]    sel_q;
   logic                    wen_q;
   logic [addressWidth-1:0] wadd_q;
   logic [dataWidth-1:0]    win_q;
   logic [numNeuron-1:0]    wsel_q;
   logic                    done_q;
   logic                    err_q;

   logic                    xfer;
   logic [7:0]              hdr_neuron;
   logic [7:0]              hdr_layer;
   logic                    layer_hit;
   logic                    neuron_ok;
   logic                    last_word;

   // Handshake and header decode; only meaningful when xfer happens in IDLE.
   assign xfer       = bus.cfg_valid && ready_q;
   assign hdr_neuron = bus.cfg_data[7:0];
   assign hdr_layer  = bus.cfg_data[15:8];
   assign layer_hit  = (hdr_layer == 8'(layerNo));
   assign neuron_ok  = ({24'd0, hdr_neuron} < 32'(numNeuron));
   assign last_word  = (cnt_q == last_idx);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values;
         // blocking '=' here would make results depend on statement order.
         state_q <= state_d;
      end
   end

   // Next-state decode: payload length is fixed, so LOAD and SKIP both
   // leave after the transfer that carries word numWeight-1.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE: if (xfer) state_d = (layer_hit && neuron_ok) ? LOAD : SKIP;
         LOAD: if (xfer && last_word) state_d = DONE;
         SKIP: if (xfer && last_word) state_d = IDLE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered datapath: counter, latched select and the write-port outputs,
   // which all appear the cycle after the accepting transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         cnt_q   <= '0;
         sel_q   <= '0;
         wen_q   <= 1'b0;
         wadd_q  <= '0;
         win_q   <= '0;
         wsel_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // Ready drops only for the single DONE cycle.
         ready_q <= (state_d != DONE);
         wen_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (xfer) begin
            unique case (state_q)
               IDLE: begin
                  cnt_q  <= '0;
                  wsel_q <= '0;
                  err_q  <= layer_hit && !neuron_ok;
                  if (layer_hit && neuron_ok) sel_q <= sel_one << hdr_neuron;
               end
               LOAD: begin
                  wen_q  <= 1'b1;
                  wadd_q <= cnt_q;
                  win_q  <= bus.cfg_data;
                  wsel_q <= sel_q;
                  done_q <= last_word;
                  cnt_q  <= last_word ? '0 : cnt_q + 1'b1;
               end
               SKIP: begin
                  cnt_q <= last_word ? '0 : cnt_q + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.cfg_ready = ready_q;
   assign bus.wen       = wen_q;
   assign bus.wadd      = wadd_q;
   assign bus.win       = win_q;
   assign bus.wsel      = wsel_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   logic [dataWidth-1:0] sum_q;

   // Running weight sum, restarted by each header that opens a LOAD; it
   // moves in step with wen so the final value lines up with done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else if (xfer && (state_q == IDLE) && layer_hit && neuron_ok) begin
         sum_q <= '0;
      end else if (xfer && (state_q == LOAD)) begin
         sum_q <= sum_q + bus.cfg_data;
      end
   end

   assign bus.checksum = sum_q;
`else
   assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: randomized packet stream against a packet-level model.
// Each packet is a header plus NW payload words; the model decides from the
// header alone whether the packet must produce NW writes (addresses 0..NW-1,
// data = payload, one-hot select), an err pulse, or nothing at all.
module tb_weight_loader;

   localparam int NW    = 4;
   localparam int NN    = 30;
   localparam int LAYER = 1;
   localparam int AW    = 10;
   localparam int DW    = 16;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [NN-1:0] sel;
      logic          done;
   } wr_t;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int errors = 0;

   wr_t  obs[$];
   int   err_cnt;
   int   done_cnt;
   logic [DW-1:0] wts [NW];

   weight_loader_if #(.dataWidth(DW), .addressWidth(AW), .numNeuron(NN)) bus ();

   weight_loader #(
      .numWeight   (NW),
      .numNeuron   (NN),
      .layerNo     (LAYER),
      .addressWidth(AW),
      .dataWidth   (DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Observe the write port away from the active edge.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (bus.wen === 1'b1) obs.push_back('{bus.wadd, bus.win, bus.wsel, bus.done});
         if (bus.err === 1'b1) err_cnt++;
         if (bus.done === 1'b1) done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] seen, input logic [63:0] want);
      checks++;
      if (seen !== want) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, seen, want);
      end
   endtask

   // Present one word and return at negedge+1 after the edge that took it.
   task automatic send(input logic [DW-1:0] word, output int waited);
      bus.cfg_data  = word;
      bus.cfg_valid = 1'b1;
      waited = 0;
      while (bus.cfg_ready !== 1'b1 && waited < 20) begin
         @(negedge clk); #1;
         waited++;
      end
      if (waited >= 20) check("ready_timeout", bus.cfg_ready, 1);
      @(negedge clk); #1;
   endtask

   task automatic run_packet(input logic [DW-1:0] hdr, input int gap_at, input int gap_len,
                             input bit hold, input int exp_wait, output bit loaded);
      int waited;
      int sum;
      bit is_load;
      bit is_err;
      logic [NN-1:0] exp_sel;
      is_load = (int'(hdr[15:8]) == LAYER) && (int'(hdr[7:0]) < NN);
      is_err  = (int'(hdr[15:8]) == LAYER) && (int'(hdr[7:0]) >= NN);
      exp_sel = is_load ? (NN'(1) << hdr[7:0]) : '0;
      obs.delete();
      err_cnt  = 0;
      done_cnt = 0;
      sum      = 0;

      send(hdr, waited);
      check("hdr_wait", waited, exp_wait);
      check("err_pulse", bus.err, is_err);

      for (int i = 0; i < NW; i++) begin
         if (i == gap_at && gap_len > 0) begin
            bus.cfg_valid = 1'b0;
            repeat (gap_len) begin
               @(negedge clk); #1;
               check("gap_ready", bus.cfg_ready, 1);
            end
         end
         send(wts[i], waited);
         sum += int'(wts[i]);
      end

      check("done_last", bus.done, is_load);
      check("ready_after_last", bus.cfg_ready, !is_load);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      if (is_load) check("checksum", bus.checksum, sum % 65536);
`else
      check("checksum_zero", bus.checksum, 0);
`endif
      check("n_writes", obs.size(), is_load ? NW : 0);
      for (int i = 0; i < obs.size() && i < NW; i++) begin
         check("wadd", obs[i].addr, i);
         check("win", obs[i].data, wts[i]);
         check("wsel", obs[i].sel, exp_sel);
         check("wdone", obs[i].done, (i == NW - 1));
      end
      check("n_done", done_cnt, is_load);
      check("n_err", err_cnt, is_err);

      if (!(hold && is_load)) begin
         bus.cfg_valid = 1'b0;
         @(negedge clk); #1;
         check("idle_ready", bus.cfg_ready, 1);
         check("idle_wen", bus.wen, 0);
         check("idle_done", bus.done, 0);
      end
      loaded = is_load;
   endtask

   initial begin
      bit loaded;
      bit held;
      int waited;
      logic [DW-1:0] hdr;

      bus.cfg_valid = 1'b0;
      bus.cfg_data  = '0;
      rst = 1'b1;
      #1;
      check("rst_ready", bus.cfg_ready, 0);
      check("rst_wen", bus.wen, 0);
      check("rst_wsel", bus.wsel, 0);
      check("rst_checksum", bus.checksum, 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      check("post_rst_ready", bus.cfg_ready, 1);
      check("post_rst_done", bus.done, 0);

      // Directed: back-to-back load of neuron 3 with weights 5..8.
      for (int i = 0; i < NW; i++) wts[i] = DW'(5 + i);
      run_packet(16'h0103, -1, 0, 1'b0, 0, loaded);
      // Same load with a two-cycle stall before the third weight.
      run_packet(16'h0103, 2, 2, 1'b0, 0, loaded);
      // Other layer is skipped, then neuron 0 loads normally.
      for (int i = 0; i < NW; i++) wts[i] = DW'($urandom_range(0, 65535));
      run_packet(16'h0203, -1, 0, 1'b0, 0, loaded);
      for (int i = 0; i < NW; i++) wts[i] = DW'($urandom_range(0, 65535));
      run_packet(16'h0100, -1, 0, 1'b0, 0, loaded);
      // Out-of-range neuron raises err and consumes its payload.
      run_packet(16'h01FF, 1, 1, 1'b0, 0, loaded);

      // Reset in the middle of a load, then a clean reload.
      send(16'h0103, waited);
      send(16'h1111, waited);
      send(16'h2222, waited);
      rst = 1'b1;
      #1;
      check("mid_rst_wen", bus.wen, 0);
      check("mid_rst_wadd", bus.wadd, 0);
      check("mid_rst_win", bus.win, 0);
      check("mid_rst_wsel", bus.wsel, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_err", bus.err, 0);
      check("mid_rst_checksum", bus.checksum, 0);
      check("mid_rst_ready", bus.cfg_ready, 0);
      bus.cfg_valid = 1'b0;
      @(negedge clk); #1 rst = 1'b0;
      @(negedge clk); #1;
      for (int i = 0; i < NW; i++) wts[i] = DW'($urandom_range(0, 65535));
      run_packet(16'h0103, -1, 0, 1'b0, 0, loaded);

      // cfg_valid held through DONE: the next header waits exactly one cycle.
      for (int i = 0; i < NW; i++) wts[i] = DW'($urandom_range(0, 65535));
      run_packet(16'h0107, -1, 0, 1'b1, 0, loaded);
      held = loaded;
      for (int i = 0; i < NW; i++) wts[i] = DW'($urandom_range(0, 65535));
      run_packet(16'h0105, -1, 0, 1'b0, held ? 1 : 0, loaded);
      held = 1'b0;

      // Randomized packet mix.
      for (int p = 0; p < 16; p++) begin
         int r;
         bit hold;
         hdr[15:8] = ($urandom_range(0, 3) == 0) ? 8'd2 : 8'(LAYER);
         r = int'($urandom_range(0, 9));
         hdr[7:0] = (r == 0) ? 8'd255 : (r == 1) ? 8'(NN) : 8'($urandom_range(0, NN - 1));
         for (int i = 0; i < NW; i++) wts[i] = DW'($urandom_range(0, 65535));
         hold = 1'($urandom_range(0, 1));
         run_packet(hdr, int'($urandom_range(0, NW - 1)), int'($urandom_range(0, 2)),
                    hold, held ? 1 : 0, loaded);
         held = hold && loaded;
      end

      bus.cfg_valid = 1'b0;
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_loader.md
# weight_loader

Write-side front end for the per-neuron weight memories of one layer when weights are not compiled in as pretrained ROM contents. Accepts a serial configuration stream of header and weight words and drives the write ports (write enable, address, data) of the layer's weight memories, with a one-hot neuron select. Sits between the host/config interface and the `numNeuron` weight memories of layer `layerNo`.

## Interface
- `numWeight`, 784: weights per neuron; payload words following each header.
- `numNeuron`, 30: weight memories (neurons) in this layer.
- `layerNo`, 1: layer this instance serves; headers for other layers are skipped.
- `addressWidth`, 10: weight address width; must satisfy 2^addressWidth >= numWeight.
- `dataWidth`, 16: weight/stream word width; must be >= 16.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cfg_valid` input 1: stream word present.
- `cfg_data` input dataWidth: header or weight word.
- `cfg_ready` output 1: loader accepts word; transfer when `cfg_valid && cfg_ready`.
- `wen` output 1: weight memory write enable.
- `wadd` output addressWidth: weight address.
- `win` output dataWidth: weight data.
- `wsel` output numNeuron: one-hot memory select; memory k writes when `wen && wsel[k]`.
- `done` output 1: one-cycle pulse, neuron fully loaded.
- `err` output 1: one-cycle pulse, header neuron index out of range.
- `checksum` output dataWidth: running weight sum (see Configuration).

## Operation
- Header word: `cfg_data[7:0]` = neuron index, `cfg_data[15:8]` = layer number; upper bits ignored.
- States: IDLE, LOAD, SKIP, DONE.
- IDLE: `cfg_ready`=1. On transfer, decode header: layer == layerNo and neuron < numNeuron → LOAD, latch one-hot select; layer == layerNo and neuron >= numNeuron → pulse `err`, SKIP; layer != layerNo → SKIP (no err). Weight counter cleared.
- LOAD: `cfg_ready`=1. Each transfer writes one weight at address = counter, counter +1. Transfer with counter == numWeight-1 → DONE.
- SKIP: `cfg_ready`=1. Accept and discard numWeight words, no writes; after the last → IDLE. No `done`.
- DONE: `cfg_ready`=0 for exactly one cycle, then IDLE. `cfg_valid` during DONE ignored and held by the source.
- Counter width addressWidth; never wraps (exit at numWeight-1). numWeight=1: header then one weight → DONE.
- Stalls (`cfg_valid`=0) anywhere hold state and counter; no writes issued.
- Reset mid-load: state IDLE, counter 0; words already written stay in memory; host resends full header+payload.

## Timing
- Reset values: `cfg_ready`=0 while `rst` asserted, 1 in IDLE after release; `wen`=0, `wadd`=0, `win`=0, `wsel`=0, `done`=0, `err`=0, `checksum`=0.
- All outputs registered. Weight transfer in cycle N → `wen`=1, `wadd`, `win`, `wsel` valid in cycle N+1 only; `wen`=0 on any cycle without a preceding LOAD transfer.
- `done` asserts in the same cycle as the final `wen` (cycle N+1 of last transfer), i.e. the DONE-state cycle.
- `err` asserts cycle after the offending header transfer.
- Throughput: one word per cycle; full neuron = 1 + numWeight transfers + 1 dead cycle.
- `wsel` holds its one-hot value from the first write until next header; only qualified by `wen`.

## Configuration
- `WEIGHT_LOADER_CHECKSUM_EN` defined: `checksum` = sum modulo 2^dataWidth of all weights written since the last accepted matching header, cleared on that header and on reset; updates in the same cycle as the corresponding `wen`; final value valid with `done`.
- Not defined: adder omitted, `checksum` tied to 0.

## Test plan
- numWeight=4, layerNo=1: header 0x0103, weights 5,6,7,8 back-to-back → wen on 4 consecutive cycles, wadd 0..3, win 5..8, wsel=1<<3, done with last write, checksum 26 (when enabled).
- Same sequence with `cfg_valid` dropped 2 cycles between weights 2 and 3 → writes identical, no wen during gap, cfg_ready stays 1.
- Header 0x0203 (layer 2) + 4 words → no wen, no done, no err; next header 0x0100 loads neuron 0 normally.
- Header 0x01FF (neuron 255 ≥ numNeuron) → err pulse one cycle later, 4 following words consumed with no writes, back to IDLE.
- `rst` pulsed after 2 of 4 weights → all outputs zero immediately, subsequent full header+4 weights loads cleanly from wadd 0.
- cfg_valid held 1 through DONE → cfg_ready 0 for exactly one cycle after last weight, next word accepted as header.
